// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, access owner IDs, default widths.
package mem_port_arbiter_pkg;

    localparam int unsigned AW_DEF = 10;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/return bus plus the single memory port, bundled for the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = mem_port_arbiter_pkg::AW_DEF,
    parameter int unsigned DW = mem_port_arbiter_pkg::DW_DEF
);
    logic          halt;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// Open-slot winner selection: data has priority unless fetch has lost MAX_STARVE times in a row.
module mem_port_arbiter_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_open,
    input  logic i_if_req,
    input  logic i_dm_req,
    output logic o_if_gnt,
    output logic o_dm_gnt
);

    localparam int unsigned SW = $clog2(MAX_STARVE + 1);

    logic [SW-1:0] r_starve;
    logic          w_starved;

    always_comb begin
        w_starved = (r_starve == SW'(MAX_STARVE));
        o_if_gnt  = i_open && i_if_req && (!i_dm_req || w_starved);
        o_dm_gnt  = i_open && i_dm_req && !o_if_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (o_dm_gnt && i_if_req) begin
            r_starve <= w_starved ? r_starve : r_starve + SW'(1);
        end else if (o_if_gnt || !i_if_req) begin
            r_starve <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access; one access per slot.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned MAX_STARVE = 2
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CW = $clog2(MEM_LAT + 1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    owner_e        r_own;

    logic          w_last_wait;
    logic          w_open;
    logic          w_if_gnt;
    logic          w_dm_gnt;
    logic          w_acc_we;
    logic [AW-1:0] w_acc_addr;
    logic [DW-1:0] w_acc_wdata;

    always_comb begin
        w_last_wait = (r_state == ST_WAIT) && (r_cnt == CW'(1));
        w_open      = rst_n && !bus.halt &&
                      ((r_state == ST_IDLE) || ((r_state == ST_ISSUE) && bus.mem_we) || w_last_wait);
        w_acc_we    = w_dm_gnt && bus.dm_we;
        w_acc_addr  = w_dm_gnt ? bus.dm_addr : bus.if_addr;
        w_acc_wdata = w_acc_we ? bus.dm_wdata : '0;
        bus.if_gnt  = w_if_gnt;
        bus.dm_gnt  = w_dm_gnt;
    end

    mem_port_arbiter_select #(
        .MAX_STARVE(MAX_STARVE)
    ) u_select (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_open  (w_open),
        .i_if_req(bus.if_req),
        .i_dm_req(bus.dm_req),
        .o_if_gnt(w_if_gnt),
        .o_dm_gnt(w_dm_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_own         <= OWN_IF;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rvalid <= 1'b0;
            bus.dm_rdata  <= '0;
        end else begin
            bus.if_rvalid <= 1'b0;
            bus.dm_rvalid <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;

            if (w_last_wait) begin
                if (r_own == OWN_DM) begin
                    bus.dm_rdata  <= bus.mem_rdata;
                    bus.dm_rvalid <= 1'b1;
                end else begin
                    bus.if_rdata  <= bus.mem_rdata;
                    bus.if_rvalid <= 1'b1;
                end
            end

            case (r_state)
                ST_ISSUE: begin
                    if (bus.mem_we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CW'(MEM_LAT);
                    end
                end
                ST_WAIT: begin
                    if (w_last_wait) r_state <= ST_IDLE;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                default: r_state <= ST_IDLE;
            endcase

            // A new accept overrides the transition above, giving back-to-back issue.
            if (w_if_gnt || w_dm_gnt) begin
                r_state       <= ST_ISSUE;
                r_own         <= w_dm_gnt ? OWN_DM : OWN_IF;
                bus.mem_en    <= 1'b1;
                bus.mem_we    <= w_acc_we;
                bus.mem_addr  <= w_acc_addr;
                bus.mem_wdata <= w_acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) checked each cycle against a slot/queue model.
module tb_mem_port_arbiter;

    localparam int MAXS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(10), .DW(32)) bus0 ();
    mem_port_arbiter_if #(.AW(10), .DW(32)) bus1 ();

    mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .MAX_STARVE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .MAX_STARVE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic logic [31:0] init_word(input logic [9:0] a);
        return (a == 10'd5) ? 32'h2002_0007 : (32'hC0DE_0000 | {22'd0, a});
    endfunction

    // Memory environment: read data appears MEM_LAT cycles after the mem_en sample edge.
    bit          ev0 [1024];
    logic [31:0] ed0 [1024];
    logic [31:0] p0;
    bit          ev1 [1024];
    logic [31:0] ed1 [1024];
    logic [31:0] p1 [3];

    always @(posedge clk) begin
        if (bus0.mem_en && bus0.mem_we) begin
            ev0[bus0.mem_addr] <= 1'b1;
            ed0[bus0.mem_addr] <= bus0.mem_wdata;
        end
        p0 <= (bus0.mem_en && !bus0.mem_we) ?
              (ev0[bus0.mem_addr] ? ed0[bus0.mem_addr] : init_word(bus0.mem_addr)) : 32'hBAD0_BAD0;
    end
    assign bus0.mem_rdata = p0;

    always @(posedge clk) begin
        if (bus1.mem_en && bus1.mem_we) begin
            ev1[bus1.mem_addr] <= 1'b1;
            ed1[bus1.mem_addr] <= bus1.mem_wdata;
        end
        p1[0] <= (bus1.mem_en && !bus1.mem_we) ?
                 (ev1[bus1.mem_addr] ? ed1[bus1.mem_addr] : init_word(bus1.mem_addr)) : 32'hBAD1_BAD1;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign bus1.mem_rdata = p1[2];

    // Model state: blocked-cycle count, starvation count, return timeline, expected port contents.
    int          blk [2];
    int          starve [2];
    bit          lv [2][16];
    bit          lo [2][16];
    logic [31:0] ld [2][16];
    logic        ce [2];
    logic        cw [2];
    logic [9:0]  ca [2];
    logic [31:0] cd [2];
    logic [31:0] last_if [2];
    logic [31:0] last_dm [2];
    bit          mv [2][1024];
    logic [31:0] md [2][1024];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic g_if [2];
    logic g_dm [2];
    logic g_iv [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input int k, input logic [9:0] a);
        return mv[k][a] ? md[k][a] : init_word(a);
    endfunction

    task automatic model_cmp(
        input int k, input int lat, input logic rst, input logic hlt,
        input logic ireq, input logic [9:0] iad,
        input logic dreq, input logic dwe, input logic [9:0] dad, input logic [31:0] dwd,
        input logic a_ig, input logic a_iv, input logic [31:0] a_id,
        input logic a_dg, input logic a_dv, input logic [31:0] a_dd,
        input logic a_en, input logic a_we, input logic [9:0] a_ad, input logic [31:0] a_wd);
        logic open, e_ig, e_dg, e_iv, e_dv;
        if (!rst) begin
            blk[k] = 0; starve[k] = 0;
            for (int i = 0; i < 16; i++) lv[k][i] = 1'b0;
            ce[k] = 1'b0; cw[k] = 1'b0; ca[k] = '0; cd[k] = '0;
            last_if[k] = '0; last_dm[k] = '0;
        end
        e_iv = lv[k][0] && !lo[k][0];
        e_dv = lv[k][0] && lo[k][0];
        if (e_iv) last_if[k] = ld[k][0];
        if (e_dv) last_dm[k] = ld[k][0];
        open = rst && !hlt && (blk[k] == 0);
        e_ig = open && ireq && (!dreq || starve[k] == MAXS);
        e_dg = open && dreq && !e_ig;
        chk($sformatf("d%0d.if_gnt", k),    a_ig, e_ig);
        chk($sformatf("d%0d.dm_gnt", k),    a_dg, e_dg);
        chk($sformatf("d%0d.if_rvalid", k), a_iv, e_iv);
        chk($sformatf("d%0d.dm_rvalid", k), a_dv, e_dv);
        chk($sformatf("d%0d.if_rdata", k),  a_id, last_if[k]);
        chk($sformatf("d%0d.dm_rdata", k),  a_dd, last_dm[k]);
        chk($sformatf("d%0d.mem_en", k),    a_en, ce[k]);
        chk($sformatf("d%0d.mem_we", k),    a_we, cw[k]);
        chk($sformatf("d%0d.mem_addr", k),  a_ad, ca[k]);
        chk($sformatf("d%0d.mem_wdata", k), a_wd, cd[k]);
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                lv[k][i] = lv[k][i+1]; lo[k][i] = lo[k][i+1]; ld[k][i] = ld[k][i+1];
            end
            lv[k][15] = 1'b0;
            if (blk[k] > 0) blk[k]--;
            ce[k] = 1'b0; cw[k] = 1'b0; ca[k] = '0; cd[k] = '0;
            if (e_dg && ireq)         starve[k] = (starve[k] < MAXS) ? starve[k] + 1 : MAXS;
            else if (e_ig || !ireq)   starve[k] = 0;
            if (e_ig) begin
                ce[k] = 1'b1; ca[k] = iad; blk[k] = lat;
                lv[k][lat+1] = 1'b1; lo[k][lat+1] = 1'b0; ld[k][lat+1] = mread(k, iad);
            end
            if (e_dg) begin
                ce[k] = 1'b1; cw[k] = dwe; ca[k] = dad; cd[k] = dwe ? dwd : '0;
                if (dwe) begin
                    mv[k][dad] = 1'b1; md[k][dad] = dwd;
                end else begin
                    blk[k] = lat;
                    lv[k][lat+1] = 1'b1; lo[k][lat+1] = 1'b1; ld[k][lat+1] = mread(k, dad);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cmp(0, 1, rst_n, bus0.halt, bus0.if_req, bus0.if_addr, bus0.dm_req, bus0.dm_we,
                  bus0.dm_addr, bus0.dm_wdata, bus0.if_gnt, bus0.if_rvalid, bus0.if_rdata,
                  bus0.dm_gnt, bus0.dm_rvalid, bus0.dm_rdata, bus0.mem_en, bus0.mem_we,
                  bus0.mem_addr, bus0.mem_wdata);
        model_cmp(1, 3, rst_n, bus1.halt, bus1.if_req, bus1.if_addr, bus1.dm_req, bus1.dm_we,
                  bus1.dm_addr, bus1.dm_wdata, bus1.if_gnt, bus1.if_rvalid, bus1.if_rdata,
                  bus1.dm_gnt, bus1.dm_rvalid, bus1.dm_rdata, bus1.mem_en, bus1.mem_we,
                  bus1.mem_addr, bus1.mem_wdata);
        g_if[0] = bus0.if_gnt; g_dm[0] = bus0.dm_gnt; g_iv[0] = bus0.if_rvalid;
        g_if[1] = bus1.if_gnt; g_dm[1] = bus1.dm_gnt; g_iv[1] = bus1.if_rvalid;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         ng;
        int         nv;
        logic [5:0] seq;

        bus0.halt = 0; bus0.if_req = 0; bus0.if_addr = '0;
        bus0.dm_req = 0; bus0.dm_we = 0; bus0.dm_addr = '0; bus0.dm_wdata = '0;
        bus1.halt = 0; bus1.if_req = 0; bus1.if_addr = '0;
        bus1.dm_req = 0; bus1.dm_we = 0; bus1.dm_addr = '0; bus1.dm_wdata = '0;

        // Reset: a pending request must not be granted while rst_n is low.
        bus0.if_req = 1; bus0.if_addr = 10'd3;
        tick();
        chk("rst_if_gnt", g_if[0], 1'b0);
        tick();
        chk("rst_mem_en", bus0.mem_en, 1'b0);
        bus0.if_req = 0;
        rst_n = 1;
        tick();

        // IF-only read of address 5 on MEM_LAT=1.
        bus0.if_req = 1; bus0.if_addr = 10'd5;
        tick();
        chk("A_if_gnt", g_if[0], 1'b1);
        bus0.if_req = 0;
        chk("A_mem_en", bus0.mem_en, 1'b1);
        chk("A_mem_addr", bus0.mem_addr, 10'd5);
        tick();
        chk("A_no_early_rvalid", bus0.if_rvalid, 1'b0);
        tick();
        chk("A_if_rvalid", bus0.if_rvalid, 1'b1);
        chk("A_if_rdata", bus0.if_rdata, 32'h2002_0007);
        tick();

        // Both requesting loads continuously: grant order DM,DM,IF,DM,DM,IF.
        bus0.if_req = 1; bus0.if_addr = 10'd20;
        bus0.dm_req = 1; bus0.dm_we = 0; bus0.dm_addr = 10'd30;
        ng = 0; seq = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (g_if[0] || g_dm[0]) begin
                seq = {seq[4:0], g_if[0]};
                ng++;
            end
        end
        chk("B_grant_count", ng, 6);
        chk("B_grant_order", seq, 6'b001001);
        bus0.if_req = 0; bus0.dm_req = 0;
        repeat (4) tick();

        // Store to 12 then pending IF read of 12 granted during the store's issue slot.
        bus0.dm_req = 1; bus0.dm_we = 1; bus0.dm_addr = 10'd12; bus0.dm_wdata = 32'hDEAD_BEEF;
        bus0.if_req = 1; bus0.if_addr = 10'd12;
        tick();
        chk("C_dm_gnt", g_dm[0], 1'b1);
        bus0.dm_req = 0; bus0.dm_we = 0;
        chk("C_mem_we", bus0.mem_we, 1'b1);
        chk("C_mem_wdata", bus0.mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("C_if_gnt_in_store", g_if[0], 1'b1);
        bus0.if_req = 0;
        chk("C_mem_we_one_cycle", bus0.mem_we, 1'b0);
        chk("C_read_issue", bus0.mem_en, 1'b1);
        tick();
        tick();
        chk("C_if_rvalid", bus0.if_rvalid, 1'b1);
        chk("C_if_rdata", bus0.if_rdata, 32'hDEAD_BEEF);
        tick();

        // halt with an IF read in flight and both stages requesting.
        bus0.if_req = 1; bus0.if_addr = 10'd7;
        tick();
        chk("D_if_gnt", g_if[0], 1'b1);
        bus0.halt = 1; bus0.if_addr = 10'd8;
        bus0.dm_req = 1; bus0.dm_we = 0; bus0.dm_addr = 10'd9;
        ng = 0; nv = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (g_if[0] || g_dm[0]) ng++;
            if (g_iv[0]) nv++;
        end
        chk("D_no_gnt_halted", ng, 0);
        chk("D_one_rvalid", nv, 1);
        chk("D_rdata", bus0.if_rdata, init_word(10'd7));
        bus0.if_req = 0; bus0.dm_req = 0; bus0.halt = 0;
        tick();

        // MEM_LAT=3: slot reopens only at the last wait cycle.
        bus1.if_req = 1; bus1.if_addr = 10'd40;
        tick();
        chk("E_if_gnt", g_if[1], 1'b1);
        bus1.if_addr = 10'd41;
        ng = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (g_if[1]) ng++;
        end
        chk("E_no_gnt_cnt32", ng, 0);
        tick();
        chk("E_gnt_at_cnt1", g_if[1], 1'b1);
        bus1.if_req = 0;
        chk("E_if_rvalid", bus1.if_rvalid, 1'b1);
        chk("E_if_rdata", bus1.if_rdata, init_word(10'd40));
        repeat (4) tick();
        chk("E_second_rvalid", bus1.if_rvalid, 1'b1);
        chk("E_second_rdata", bus1.if_rdata, init_word(10'd41));
        tick();

        // Reset during the WAIT of an IF read discards it.
        bus1.if_req = 1; bus1.if_addr = 10'd50;
        tick();
        chk("F_if_gnt", g_if[1], 1'b1);
        bus1.if_req = 0;
        tick();
        tick();
        rst_n = 0;
        tick();
        chk("F_rst_mem_en", bus1.mem_en, 1'b0);
        chk("F_rst_rdata", bus1.if_rdata, 32'h0);
        rst_n = 1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (g_iv[1]) nv++;
        end
        chk("F_no_rvalid_after_rst", nv, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
